// File: rtl/ro_puf_pkg.sv
`timescale 1ns/1ps
// Shared types and challenge layout for the ring-oscillator pair PUF.
package ro_puf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_COMPARE
  } state_e;

  // challenge = {idx_a, idx_b}; field number times SEL_W gives each index LSB
  localparam int unsigned CHAL_FIELD_A = 1;
  localparam int unsigned CHAL_FIELD_B = 0;

endpackage

// File: rtl/ro_chain.sv
`timescale 1ns/1ps
// One enable-gated ring oscillator: NAND(enable, out) followed by
// NUM_STAGES-1 inverters. The delay only shapes simulation behaviour.
module ro_chain #(
  parameter int  NUM_STAGES  = 15,
  parameter real STAGE_DELAY = 1.0
) (
  input  logic enable,
  output logic out
);

  logic nand_out;

  // Whole-ring delay is lumped on the NAND so the zero-delay inverters always
  // hold a self-consistent state and the loop starts cleanly on enable.
  assign #(NUM_STAGES * STAGE_DELAY) nand_out = ~(enable & out);

  for (genvar i = 0; i < NUM_STAGES - 1; i++) begin : g_inv
    logic y;
    if (i == 0) begin : g_first
      assign y = ~nand_out;
    end else begin : g_next
      assign y = ~g_inv[i-1].y;
    end
  end

  assign out = g_inv[NUM_STAGES-2].y;

endmodule

// File: rtl/ro_pair_puf.sv
`timescale 1ns/1ps
// Ring-oscillator pair PUF: enables two oscillators of a bank, counts their
// synchronised rising edges over a fixed window and compares the counts.
//
// state      | meaning
// IDLE       | waiting for start, challenge latched on accepted start
// SETTLE     | pair enabled, synchroniser and edge detector flushing
// MEASURE    | WINDOW cycles of rising-edge counting
// COMPARE    | results registered, done pulsed
module ro_pair_puf
  import ro_puf_pkg::*;
#(
  parameter int  N_RO        = 8,
  parameter int  NUM_STAGES  = 15,
  parameter int  SEL_W       = $clog2(N_RO),
  parameter int  WINDOW      = 1024,
  parameter int  CNT_W       = 16,
  parameter int  SYNC_STAGES = 2,
  parameter real STAGE_DELAY = 1.0,
  parameter real DELAY_STEP  = 0.0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*SEL_W-1:0] challenge,
  output logic               busy,
  output logic               done,
  output logic               response,
  output logic [CNT_W-1:0]   count_a,
  output logic [CNT_W-1:0]   count_b,
  output logic               tie,
  output logic               err
);

  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam int SET_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e                 state_q, state_d;
  logic [N_RO-1:0]        en_q, en_d;
  logic [SEL_W-1:0]       idx_a_q, idx_a_d, idx_b_q, idx_b_d;
  logic [SET_W-1:0]       settle_q, settle_d;
  logic [WIN_W-1:0]       win_q, win_d;
  logic [CNT_W-1:0]       cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic                   err_acc_q, err_acc_d;
  logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d, sync_b_q, sync_b_d;
  logic                   prev_a_q, prev_a_d, prev_b_q, prev_b_d;
  logic                   busy_q, busy_d, done_q, done_d, resp_q, resp_d;
  logic                   tie_q, tie_d, err_q, err_d;
  logic [CNT_W-1:0]       count_a_q, count_a_d, count_b_q, count_b_d;

  logic [N_RO-1:0]  ro_out;
  logic             ro_a, ro_b;
  logic [SEL_W-1:0] chal_a, chal_b;
  logic             chal_ok, rise_a, rise_b;
  logic [N_RO-1:0]  sel_mask;

  for (genvar i = 0; i < N_RO; i++) begin : g_ro
    ro_chain #(
      .NUM_STAGES  (NUM_STAGES),
      .STAGE_DELAY (STAGE_DELAY + i * DELAY_STEP)
    ) u_ro (
      .enable (en_q[i]),
      .out    (ro_out[i])
    );
  end

  // Indices are stable for the whole measurement, so muxing before the
  // synchroniser is safe.
  assign ro_a = ro_out[idx_a_q];
  assign ro_b = ro_out[idx_b_q];

  always_comb begin
    chal_a  = challenge[CHAL_FIELD_A*SEL_W +: SEL_W];
    chal_b  = challenge[CHAL_FIELD_B*SEL_W +: SEL_W];
    chal_ok = (int'(chal_a) < N_RO) && (int'(chal_b) < N_RO) && (chal_a != chal_b);
    sel_mask = '0;
    for (int i = 0; i < N_RO; i++) begin
      sel_mask[i] = (i == int'(chal_a)) || (i == int'(chal_b));
    end
    rise_a = sync_a_q[SYNC_STAGES-1] & ~prev_a_q;
    rise_b = sync_b_q[SYNC_STAGES-1] & ~prev_b_q;

    state_d   = state_q;
    en_d      = en_q;
    idx_a_d   = idx_a_q;
    idx_b_d   = idx_b_q;
    settle_d  = settle_q;
    win_d     = win_q;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;
    err_acc_d = err_acc_q;
    sync_a_d  = {sync_a_q[SYNC_STAGES-2:0], ro_a};
    sync_b_d  = {sync_b_q[SYNC_STAGES-2:0], ro_b};
    prev_a_d  = sync_a_q[SYNC_STAGES-1];
    prev_b_d  = sync_b_q[SYNC_STAGES-1];
    busy_d    = busy_q;
    done_d    = 1'b0;
    resp_d    = resp_q;
    tie_d     = tie_q;
    err_d     = err_q;
    count_a_d = count_a_q;
    count_b_d = count_b_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_a_d   = chal_a;
          idx_b_d   = chal_b;
          cnt_a_d   = '0;
          cnt_b_d   = '0;
          busy_d    = 1'b1;
          err_acc_d = ~chal_ok;
          if (chal_ok) begin
            en_d     = sel_mask;
            settle_d = SET_W'(SYNC_STAGES + 1);
            state_d  = ST_SETTLE;
          end else begin
            state_d  = ST_COMPARE;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          win_d   = WIN_W'(WINDOW - 1);
          state_d = ST_MEASURE;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      ST_MEASURE: begin
        if (rise_a) begin
          if (cnt_a_q == CNT_MAX) err_acc_d = 1'b1;
          else                    cnt_a_d   = cnt_a_q + CNT_W'(1);
        end
        if (rise_b) begin
          if (cnt_b_q == CNT_MAX) err_acc_d = 1'b1;
          else                    cnt_b_d   = cnt_b_q + CNT_W'(1);
        end
        if (win_q == '0) begin
          en_d    = '0;
          state_d = ST_COMPARE;
        end else begin
          win_d = win_q - WIN_W'(1);
        end
      end
      ST_COMPARE: begin
        count_a_d = cnt_a_q;
        count_b_d = cnt_b_q;
        resp_d    = cnt_a_q > cnt_b_q;
        tie_d     = cnt_a_q == cnt_b_q;
        err_d     = err_acc_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        en_d      = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      en_q      <= '0;
      idx_a_q   <= '0;
      idx_b_q   <= '0;
      settle_q  <= '0;
      win_q     <= '0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      err_acc_q <= 1'b0;
      sync_a_q  <= '0;
      sync_b_q  <= '0;
      prev_a_q  <= 1'b0;
      prev_b_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      resp_q    <= 1'b0;
      tie_q     <= 1'b0;
      err_q     <= 1'b0;
      count_a_q <= '0;
      count_b_q <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      idx_a_q   <= idx_a_d;
      idx_b_q   <= idx_b_d;
      settle_q  <= settle_d;
      win_q     <= win_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      err_acc_q <= err_acc_d;
      sync_a_q  <= sync_a_d;
      sync_b_q  <= sync_b_d;
      prev_a_q  <= prev_a_d;
      prev_b_q  <= prev_b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      resp_q    <= resp_d;
      tie_q     <= tie_d;
      err_q     <= err_d;
      count_a_q <= count_a_d;
      count_b_q <= count_b_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign response = resp_q;
  assign count_a  = count_a_q;
  assign count_b  = count_b_q;
  assign tie      = tie_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ro_pair_puf.sv
`timescale 1ns/1ps
// Bench for ro_pair_puf: three configurations (skewed bank, matched bank with
// six oscillators, 4-bit counters) checked against a period-based count model.
module tb_ro_pair_puf;

  localparam int    WIN    = 300;
  localparam int    SYNC   = 2;
  localparam int    STAGES = 15;
  localparam real   CLK_NS = 10.0;

  typedef struct {
    int busy, done, resp, ca, cb, tie, err, en;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] chal = '0;
  logic       start_a = 1'b0, start_t = 1'b0, start_s = 1'b0;
  logic       busy_a, done_a, resp_a, tie_a, err_a;
  logic       busy_t, done_t, resp_t, tie_t, err_t;
  logic       busy_s, done_s, resp_s, tie_s, err_s;
  logic [15:0] cnta_a, cntb_a, cnta_t, cntb_t;
  logic [3:0]  cnta_s, cntb_s;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  ro_pair_puf #(.N_RO(8), .WINDOW(WIN), .CNT_W(16), .SYNC_STAGES(SYNC),
                .NUM_STAGES(STAGES), .STAGE_DELAY(1.0), .DELAY_STEP(0.1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .challenge(chal), .busy(busy_a),
    .done(done_a), .response(resp_a), .count_a(cnta_a), .count_b(cntb_a),
    .tie(tie_a), .err(err_a));

  ro_pair_puf #(.N_RO(6), .WINDOW(WIN), .CNT_W(16), .SYNC_STAGES(SYNC),
                .NUM_STAGES(STAGES), .STAGE_DELAY(1.0), .DELAY_STEP(0.0)) u_t (
    .clk(clk), .rst(rst), .start(start_t), .challenge(chal), .busy(busy_t),
    .done(done_t), .response(resp_t), .count_a(cnta_t), .count_b(cntb_t),
    .tie(tie_t), .err(err_t));

  ro_pair_puf #(.N_RO(8), .WINDOW(WIN), .CNT_W(4), .SYNC_STAGES(SYNC),
                .NUM_STAGES(STAGES), .STAGE_DELAY(1.0), .DELAY_STEP(0.1)) u_s (
    .clk(clk), .rst(rst), .start(start_s), .challenge(chal), .busy(busy_s),
    .done(done_s), .response(resp_s), .count_a(cnta_s), .count_b(cntb_s),
    .tie(tie_s), .err(err_s));

  task automatic chk(input string tag, input int obs, input int exp, input int tol = 0);
    n_checks++;
    if (obs > exp + tol || obs < exp - tol) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int cfg_nro(input int inst);
    return (inst == 1) ? 6 : 8;
  endfunction

  function automatic real cfg_step(input int inst);
    return (inst == 1) ? 0.0 : 0.1;
  endfunction

  function automatic int cfg_cmax(input int inst);
    return (inst == 2) ? 15 : 65535;
  endfunction

  // Edges expected in the window: window time over oscillator period.
  function automatic real exp_cnt(input real step, input int idx);
    return (WIN * CLK_NS) / (2.0 * STAGES * (1.0 + idx * step));
  endfunction

  function automatic outs_t get_outs(input int inst);
    outs_t o;
    case (inst)
      0: begin
        o.busy = int'(busy_a); o.done = int'(done_a); o.resp = int'(resp_a);
        o.ca = int'(cnta_a); o.cb = int'(cntb_a); o.tie = int'(tie_a);
        o.err = int'(err_a); o.en = int'(u_a.en_q);
      end
      1: begin
        o.busy = int'(busy_t); o.done = int'(done_t); o.resp = int'(resp_t);
        o.ca = int'(cnta_t); o.cb = int'(cntb_t); o.tie = int'(tie_t);
        o.err = int'(err_t); o.en = int'(u_t.en_q);
      end
      default: begin
        o.busy = int'(busy_s); o.done = int'(done_s); o.resp = int'(resp_s);
        o.ca = int'(cnta_s); o.cb = int'(cntb_s); o.tie = int'(tie_s);
        o.err = int'(err_s); o.en = int'(u_s.en_q);
      end
    endcase
    return o;
  endfunction

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0:       start_a = v;
      1:       start_t = v;
      default: start_s = v;
    endcase
  endtask

  // Pulses start, then waits (bounded) for done; optionally pokes start mid-run.
  task automatic measure(input int inst, input int ia, input int ib, input int poke_at,
                         output int lat, output outs_t res, output int en_bad);
    outs_t o;
    int allowed;
    bit valid;
    valid   = ia < cfg_nro(inst) && ib < cfg_nro(inst) && ia != ib;
    allowed = valid ? ((1 << ia) | (1 << ib)) : 0;
    lat     = -1;
    en_bad  = 0;
    @(negedge clk);
    chal = {3'(ia), 3'(ib)};
    set_start(inst, 1'b1);
    @(posedge clk); #1;
    set_start(inst, 1'b0);
    o = get_outs(inst);
    if ((o.en & ~allowed) != 0) en_bad = 1;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk); #1;
      o = get_outs(inst);
      if ((o.en & ~allowed) != 0) en_bad = 1;
      if (o.done == 1) begin
        lat = n;
        break;
      end
      if (n == poke_at) begin
        chal = 6'b011_101;
        set_start(inst, 1'b1);
      end else begin
        set_start(inst, 1'b0);
      end
    end
    set_start(inst, 1'b0);
    res = o;
  endtask

  task automatic check_run(input string tag, input int inst, input int ia, input int ib,
                           input int poke_at);
    outs_t r;
    int lat, en_bad, cmax;
    real ea, eb;
    bit valid, sat_a, sat_b;
    valid = ia < cfg_nro(inst) && ib < cfg_nro(inst) && ia != ib;
    measure(inst, ia, ib, poke_at, lat, r, en_bad);
    chk({tag, "_latency"}, lat, valid ? SYNC + WIN + 3 : 1);
    chk({tag, "_stray_enable"}, en_bad, 0);
    chk({tag, "_busy_at_done"}, r.busy, 0);
    if (!valid) begin
      chk({tag, "_err"}, r.err, 1);
      chk({tag, "_count_a"}, r.ca, 0);
      chk({tag, "_count_b"}, r.cb, 0);
    end else begin
      cmax  = cfg_cmax(inst);
      ea    = exp_cnt(cfg_step(inst), ia);
      eb    = exp_cnt(cfg_step(inst), ib);
      sat_a = (ea - 1.0) > cmax;
      sat_b = (eb - 1.0) > cmax;
      chk({tag, "_count_a"}, r.ca, sat_a ? cmax : int'(ea), sat_a ? 0 : 1);
      chk({tag, "_count_b"}, r.cb, sat_b ? cmax : int'(eb), sat_b ? 0 : 1);
      chk({tag, "_err"}, r.err, (sat_a || sat_b) ? 1 : 0);
      if ((sat_a && sat_b) || ea == eb) begin
        chk({tag, "_tie"}, r.tie, 1);
        chk({tag, "_response"}, r.resp, 0);
        chk({tag, "_equal_counts"}, r.ca, r.cb);
      end else begin
        chk({tag, "_tie"}, r.tie, 0);
        chk({tag, "_response"}, r.resp, (ea > eb) ? 1 : 0);
      end
    end
  endtask

  initial begin
    outs_t o;
    int seen;
    // reset and idle
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      o = get_outs(i);
      chk("rst_busy", o.busy, 0);
      chk("rst_done", o.done, 0);
      chk("rst_response", o.resp, 0);
      chk("rst_count_a", o.ca, 0);
      chk("rst_count_b", o.cb, 0);
      chk("rst_tie", o.tie, 0);
      chk("rst_err", o.err, 0);
      chk("rst_enables", o.en, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (busy_a || busy_t || busy_s) seen = 1;
    end
    chk("idle_busy", seen, 0);

    check_run("ordered", 0, 0, 1, 0);
    check_run("reversed", 0, 1, 0, 0);
    check_run("tie", 1, 2, 3, 0);
    check_run("inv_same", 0, 4, 4, 0);
    check_run("inv_range", 1, 7, 0, 0);
    check_run("saturate", 2, 0, 1, 0);

    // abort 50 cycles into MEASURE
    @(negedge clk);
    chal = {3'd0, 3'd1};
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (SYNC + 2 + 50) begin
      @(posedge clk); #1;
    end
    o = get_outs(0);
    chk("abort_pre_busy", o.busy, 1);
    chk("abort_pre_enables", o.en, 3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    o = get_outs(0);
    chk("abort_busy", o.busy, 0);
    chk("abort_done", o.done, 0);
    chk("abort_enables", o.en, 0);
    chk("abort_counts", o.ca + o.cb, 0);
    chk("abort_flags", o.resp + o.tie + o.err, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (400) begin
      @(posedge clk); #1;
      if (done_a) seen = 1;
    end
    chk("abort_no_done", seen, 0);

    check_run("busy_start", 0, 0, 1, 100);
    check_run("fresh", 0, 2, 6, 0);

    for (int k = 0; k < 5; k++) begin
      int ia, ib;
      ia = int'($urandom_range(0, 7));
      ib = ($urandom_range(0, 3) == 0) ? ia : int'($urandom_range(0, 7));
      check_run("rand", 0, ia, ib, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
